// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are captured at start; results land on the edge that ends the busy window.
module mdu_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic              is_signed, is_mul, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]  a_mag, b_mag, quo_mag, rem_mag, quo, rem;

  // Datapath works only from the latched operands.
  always_comb begin
    is_signed = (op_q == OpMult) || (op_q == OpDiv);
    is_mul    = (op_q == OpMult) || (op_q == OpMultu);
    a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = a_ext * b_ext;
    // Signed divide via magnitudes: truncates toward zero and MIN / -1 wraps to MIN.
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    quo_mag   = a_mag / b_mag;
    rem_mag   = a_mag % b_mag;
    quo       = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem       = a_neg ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = (op == OpMult || op == OpMultu) ? CntW'(MUL_LAT) : CntW'(DIV_LAT);
              busy_d  = 1'b1;
              state_d = StRun;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
          if (is_mul) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Scoreboard bench for mdu_pipe: expected HI/LO pairs are queued at issue
// and popped when busy drops.
module tb_mdu_pipe;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hl;

  always #5 clk = ~clk;

  mdu_pipe #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference: 64-bit arithmetic, {hi, lo} result, cur kept when nothing is written.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [63:0] cur);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd1: r = 64'(sa * sb);
      3'd2: r = {32'b0, av} * {32'b0, bv};
      3'd3: r = (bv == 0) ? cur : {32'(sa % sb), 32'(sa / sb)};
      3'd4: r = (bv == 0) ? cur : {av % bv, av / bv};
      3'd5: r = {av, cur[31:0]};
      3'd6: r = {cur[63:32], av};
      default: r = cur;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
  endtask

  task automatic push_exp(input logic [63:0] v);
    model_hl = v;
    exp_q.push_back(v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    op    = 3'd5;
    a     = 32'hFFFF_FFFF;
    b     = 32'd0;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    model_hl = 64'd0;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy/hi/lo=%b/%h/%h required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    int cyc;
    logic [63:0] got;
    push_exp({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc);
    vectors++;
    if (cyc != 5) begin
      miscompares++;
      $display("FAIL mult_busy_cycles: got %0d required 5", cyc);
    end
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got) begin
      miscompares++;
      $display("FAIL mult_signed: hi/lo=%h required %h", {hi, lo}, got);
    end
    push_exp({32'h0000_0001, 32'hFFFF_FFFE});
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got || cyc != 5) begin
      miscompares++;
      $display("FAIL multu: hi/lo=%h cyc=%0d required %h cyc=5", {hi, lo}, cyc, got);
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [63:0] got;
    push_exp({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    vectors++;
    if (cyc != 10) begin
      miscompares++;
      $display("FAIL div_busy_cycles: got %0d required 10", cyc);
    end
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got) begin
      miscompares++;
      $display("FAIL div_neg: hi/lo=%h required %h", {hi, lo}, got);
    end
    push_exp({32'h0000_0000, 32'h8000_0000});
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got) begin
      miscompares++;
      $display("FAIL div_min_by_m1: hi/lo=%h required %h", {hi, lo}, got);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [63:0] got;
    model_hl = model(3'd5, 32'h1234_5678, 32'd0, model_hl);
    issue(3'd5, 32'h1234_5678, 32'd0);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL mthi: busy/hi=%b/%h required 0/12345678", busy, hi);
    end
    push_exp(model_hl);
    issue(3'd4, 32'd7, 32'd0);
    wait_done(cyc);
    vectors++;
    if (cyc != 10) begin
      miscompares++;
      $display("FAIL div0_busy_cycles: got %0d required 10", cyc);
    end
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got) begin
      miscompares++;
      $display("FAIL div_by_zero_hold: hi/lo=%h required %h", {hi, lo}, got);
    end
  endtask

  // Starts on busy cycles 2 and 4 and on the completing cycle must all be dropped.
  task automatic test_ignore_busy();
    int cyc;
    logic [63:0] got;
    push_exp({32'd0, 32'd12});
    issue(3'd1, 32'd3, 32'd4);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = (cyc == 2 || cyc == 4 || cyc == 5);
      op    = (cyc == 4) ? 3'd3 : 3'd6;
      a     = (cyc == 5) ? 32'h0000_BEEF : 32'h0000_DEAD;
      b     = 32'd1;
      step();
    end
    start = 1'b0;
    op    = 3'd0;
    vectors++;
    if (cyc != 5) begin
      miscompares++;
      $display("FAIL ignore_busy_cycles: got %0d required 5", cyc);
    end
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got) begin
      miscompares++;
      $display("FAIL ignore_busy_result: hi/lo=%h required %h", {hi, lo}, got);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== got) begin
      miscompares++;
      $display("FAIL ignore_busy_after: busy/hi/lo=%b/%h required 0/%h", busy, {hi, lo}, got);
    end
  endtask

  task automatic test_operand_change();
    int cyc;
    logic [63:0] got;
    push_exp({32'd0, 32'd42});
    issue(3'd2, 32'd6, 32'd7);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      a = $urandom;
      b = $urandom;
      step();
    end
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got || cyc != 5) begin
      miscompares++;
      $display("FAIL operand_change: hi/lo=%h cyc=%0d required %h cyc=5", {hi, lo}, cyc, got);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [63:0] got;
    issue(3'd4, 32'd100, 32'd7);
    for (int i = 1; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_hl = 64'd0;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy/hi/lo=%b/%h/%h required 0/0/0", busy, hi, lo);
    end
    push_exp({32'd0, 32'd6});
    issue(3'd1, 32'd2, 32'd3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_accept: busy=%b required 1", busy);
    end
    wait_done(cyc);
    got = exp_q.pop_front();
    vectors++;
    if ({hi, lo} !== got || cyc != 5) begin
      miscompares++;
      $display("FAIL post_reset_mult: hi/lo=%h cyc=%0d required %h cyc=5", {hi, lo}, cyc, got);
    end
  endtask

  task automatic test_nop_ops();
    issue(3'd7, 32'hAAAA_AAAA, 32'd3);
    issue(3'd0, 32'h5555_5555, 32'd3);
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== model_hl) begin
      miscompares++;
      $display("FAIL nop_ops: busy/hi/lo=%b/%h required 0/%h", busy, {hi, lo}, model_hl);
    end
    model_hl = model(3'd6, 32'hCAFE_F00D, 32'd0, model_hl);
    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== model_hl) begin
      miscompares++;
      $display("FAIL mtlo: busy/hi/lo=%b/%h required 0/%h", busy, {hi, lo}, model_hl);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [2:0]  o;
    logic [31:0] av, bv;
    logic [63:0] got;
    for (int n = 0; n < 12; n++) begin
      o  = 3'($urandom_range(1, 4));
      av = $urandom;
      bv = (n % 4 == 3) ? 32'd0 : ((n % 2 == 1) ? -$urandom_range(1, 20) : $urandom);
      push_exp(model(o, av, bv, model_hl));
      issue(o, av, bv);
      wait_done(cyc);
      got = exp_q.pop_front();
      vectors++;
      if ({hi, lo} !== got || cyc != ((o <= 3'd2) ? 5 : 10)) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] op=%0d a=%h b=%h: hi/lo=%h cyc=%0d required %h",
                 n, o, av, bv, {hi, lo}, cyc, got);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    reset = 1'b1;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_operand_change();
    test_reset_mid();
    test_nop_ops();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
MDU_PIPE -- requirements
Module: mdu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width in bits (even, >= 8).
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving the multiply busy duration in cycles (>= 1).
REQ-003 The block SHALL have parameter DIV_LAT, default 10, giving the divide busy duration in cycles (>= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to execute op this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 The block SHALL have port a, input, WIDTH bits: first operand (dividend, or the value for mthi/mtlo).
REQ-009 The block SHALL have port b, input, WIDTH bits: second operand (multiplier or divisor).
REQ-010 The block SHALL have port busy, output, 1 bit, registered: an operation is in flight.
REQ-011 The block SHALL have port hi, output, WIDTH bits, registered: the HI register.
REQ-012 The block SHALL have port lo, output, WIDTH bits, registered: the LO register.

Function
REQ-013 The block SHALL implement a state machine with states IDLE and RUN, plus a down-counter wide enough to hold max(MUL_LAT, DIV_LAT).
REQ-014 In IDLE, on an edge with start=1 and op in {1,2,3,4}, the block SHALL:
- latch a, b and op;
- load the counter with MUL_LAT (ops 1,2) or DIV_LAT (ops 3,4);
- enter RUN and set busy=1 after that edge.
REQ-015 In RUN the counter SHALL decrement every edge; on the edge where it reaches 0, the block SHALL write the result to hi/lo, clear busy and return to IDLE.
- busy is high for exactly MUL_LAT or DIV_LAT cycles.
- Results are visible in the cycle busy first reads 0.
REQ-016 mult SHALL produce the signed 2*WIDTH-bit product, and multu the unsigned product: hi gets the upper WIDTH bits, lo the lower.
REQ-017 div/divu SHALL write the quotient to lo and the remainder to hi.
- Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed MIN / -1 gives lo=MIN, hi=0.
REQ-018 A divide with latched divisor 0 SHALL still run the full DIV_LAT busy period but SHALL leave hi and lo unchanged.
REQ-019 mthi (mtlo) with start=1 in IDLE SHALL write a into hi (lo) at that edge, with busy remaining 0.
REQ-020 Any start (any op) received while busy=1 SHALL be ignored entirely: no latch, no hi/lo write, no change to the count.
REQ-021 On the completing edge (counter reaching 0), start SHALL be ignored; a new operation is accepted only on edges where busy=0 before the edge.
REQ-022 start=1 with op 0 or 7 SHALL have no effect.
REQ-023 Operands SHALL be used only from the latched copies; changes on a/b during RUN SHALL NOT affect the result.
REQ-024 hi and lo SHALL never change except by REQ-015, REQ-019 or reset.
REQ-025 The consuming pipeline SHALL stall any mfhi/mflo or MDU instruction in D while (start & op in 1..4) | busy; the block itself provides busy only.

Reset
REQ-026 On an edge with reset=1 the block SHALL set busy=0, hi=0, lo=0, counter=0 and state=IDLE, overriding start.
REQ-027 A reset during RUN SHALL abandon the operation, with no partial result written.
REQ-028 After reset deasserts, the block SHALL accept a start on the very next edge.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-029 mult a=0xFFFFFFFD, b=7 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 div a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 mthi a=0x12345678, then divu a=7, b=0 -> busy for 10 cycles, hi stays 0x12345678 and lo stays at its prior value.
REQ-032 Start mult 3*4, then issue mtlo a=0xDEAD and div on the 2nd and 4th busy cycles -> both ignored, lo=12 and hi=0 at completion, busy low after exactly 5 cycles.
REQ-033 Change a/b every cycle during a multu 6*7 -> lo=42 regardless.
REQ-034 Start divu 100/7, assert reset on the 4th busy cycle -> busy=0, hi=lo=0 the next cycle; a following mult 2*3 accepted on the first post-reset edge gives lo=6 after 5 cycles.
